// File: rtl/mem_pkg.sv
// mem_pkg: shared FSM states, funct3 codes and byte-enable constants for the load/store unit.
package mem_pkg;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  localparam logic [2:0] F3_LB = 3'b000;
  localparam logic [2:0] F3_LH = 3'b001;
  localparam logic [2:0] F3_LW = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [3:0] BE_B = 4'b0001;
  localparam logic [3:0] BE_H = 4'b0011;
  localparam logic [3:0] BE_W = 4'b1111;
  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] a);
    return (f3 == F3_LH || f3 == F3_LHU) ? a[0] :
           f3 == F3_LW ? |a :
           !(f3 == F3_LB || f3 == F3_LBU);
  endfunction
endpackage

// File: rtl/load_extend.sv
// load_extend: selects the addressed byte/half lane of a word and sign- or zero-extends it.
module load_extend
  import mem_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr,
  input  logic [2:0]  funct3,
  output logic [31:0] data
);
  logic [31:0] lane;
  assign lane = rdata >> {addr, 3'b000};
  always_comb begin
    data = funct3 == F3_LB  ? {{24{lane[7]}}, lane[7:0]} :
           funct3 == F3_LH  ? {{16{lane[15]}}, lane[15:0]} :
           funct3 == F3_LBU ? {24'd0, lane[7:0]} :
           funct3 == F3_LHU ? {16'd0, lane[15:0]} : lane;
  end
endmodule

// File: rtl/data_mem_handler.sv
// data_mem_handler: load/store unit running one handshaked bus transaction per instruction.
module data_mem_handler
  import mem_pkg::*;
(
  input  logic        clk,
  input  logic        nRst,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [31:0] read_address,
  input  logic [31:0] write_address,
  input  logic [31:0] store_data,
  input  logic [2:0]  funct3,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_sel,
  output logic        bus_read,
  output logic        bus_write,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ack,
  output logic [31:0] load_data,
  output logic        stall,
  output logic        done,
  output logic        misaligned
);
  state_t state, next;
  logic req, fault, start, finish;
  logic [31:0] addr, wdata, ext;
  logic [3:0] sel;
  logic [1:0] lane_q;
  logic [2:0] f3_q;
  assign req = mem_read || mem_write;
  assign addr = mem_write ? write_address : read_address;
  assign fault = is_misaligned(funct3, addr[1:0]);
  assign start = state == IDLE && req;
  assign finish = state == BUSY && bus_ack;
  assign stall = start || state == BUSY;
  assign sel = !mem_write ? BE_W :
               funct3[1:0] == 2'b00 ? BE_B << addr[1:0] :
               funct3[1:0] == 2'b01 ? BE_H << addr[1:0] : BE_W;
  assign wdata = funct3[1:0] == 2'b00 ? {4{store_data[7:0]}} :
                 funct3[1:0] == 2'b01 ? {2{store_data[15:0]}} : store_data;
  load_extend u_ext (.rdata(bus_rdata), .addr(lane_q), .funct3(f3_q), .data(ext));
  always_comb begin
    next = state == IDLE ? (req ? (fault ? DONE : BUSY) : IDLE) :
           state == BUSY ? (bus_ack ? DONE : BUSY) : IDLE;
  end
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) state <= IDLE;
    else state <= next;
  end
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      bus_addr <= '0;
      bus_wdata <= '0;
      bus_sel <= '0;
      bus_read <= 1'b0;
      bus_write <= 1'b0;
      load_data <= '0;
      done <= 1'b0;
      misaligned <= 1'b0;
      lane_q <= '0;
      f3_q <= '0;
    end else begin
      done <= finish || (start && fault);
      misaligned <= start && fault;
      if (start) begin
        bus_addr <= {addr[31:2], 2'b00};
        bus_sel <= sel;
        bus_wdata <= wdata;
        lane_q <= addr[1:0];
        f3_q <= funct3;
        bus_read <= !mem_write && !fault;
        bus_write <= mem_write && !fault;
      end else if (finish) begin
        bus_read <= 1'b0;
        bus_write <= 1'b0;
        // bus_rdata is only valid alongside the ack, so capture it here
        if (bus_read) load_data <= ext;
      end
    end
  end
endmodule

// File: tb/tb_data_mem_handler.sv
// tb_data_mem_handler: randomized and directed check of the load/store unit against a cycle model.
module tb_data_mem_handler;
  logic clk = 1'b0;
  logic nRst, mem_read, mem_write, bus_read, bus_write, bus_ack, stall, done, misaligned;
  logic [31:0] read_address, write_address, store_data, bus_addr, bus_wdata, bus_rdata, load_data;
  logic [2:0] funct3;
  logic [3:0] bus_sel;
  int total = 0, bad = 0;
  logic check_en = 1'b0;
  logic exp_stall = 1'b0, exp_rd = 1'b0, exp_wr = 1'b0, exp_done = 1'b0, exp_mis = 1'b0;
  logic [31:0] exp_ld = '0, exp_addr = '0, exp_wdata = '0;
  logic [3:0] exp_sel = '0;
  logic cap_rd = 1'b0, cap_wr = 1'b0;
  logic [31:0] cap_addr = '0, cap_wdata = '0;
  logic [3:0] cap_sel = '0;
  int n_done = 0, n_mis = 0, run = 0, last_run = 0, d0, m0;
  logic [2:0] st_f3 [6] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd6, 3'd7};

  data_mem_handler dut (
    .clk(clk), .nRst(nRst), .mem_read(mem_read), .mem_write(mem_write),
    .read_address(read_address), .write_address(write_address), .store_data(store_data),
    .funct3(funct3), .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_sel(bus_sel),
    .bus_read(bus_read), .bus_write(bus_write), .bus_rdata(bus_rdata), .bus_ack(bus_ack),
    .load_data(load_data), .stall(stall), .done(done), .misaligned(misaligned)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic model_fault(input logic [2:0] f3, input logic [1:0] off);
    case (f3)
      3'd0, 3'd4: return 1'b0;
      3'd1, 3'd5: return off[0];
      3'd2: return off != 2'd0;
      default: return 1'b1;
    endcase
  endfunction

  function automatic int model_bytes(input logic [2:0] f3);
    return f3[1:0] == 2'd0 ? 1 : f3[1:0] == 2'd1 ? 2 : 4;
  endfunction

  function automatic logic [3:0] model_sel(input logic [2:0] f3, input logic [1:0] off, input bit wr);
    logic [3:0] s = '0;
    int n = model_bytes(f3);
    if (!wr) return 4'hF;
    for (int i = 0; i < 4; i++) if (i >= int'(off) && i < int'(off) + n) s[i] = 1'b1;
    return s;
  endfunction

  function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] sd);
    logic [31:0] w;
    int n = model_bytes(f3);
    for (int i = 0; i < 4; i++) w[8*i +: 8] = sd[8*(i % n) +: 8];
    return w;
  endfunction

  function automatic logic [31:0] model_ext(input logic [31:0] rdata, input logic [1:0] off, input logic [2:0] f3);
    logic [31:0] w = rdata >> (8 * int'(off));
    int v;
    case (f3)
      3'd0: v = byte'(w[7:0]);
      3'd1: v = shortint'(w[15:0]);
      3'd4: v = int'(w & 32'h0000_00FF);
      3'd5: v = int'(w & 32'h0000_FFFF);
      default: v = int'(w);
    endcase
    return v;
  endfunction

  always @(negedge clk) begin
    if (check_en) begin
      chk("stall", stall, exp_stall);
      chk("bus_read", bus_read, exp_rd);
      chk("bus_write", bus_write, exp_wr);
      chk("done", done, exp_done);
      chk("misaligned", misaligned, exp_mis);
      chk("load_data", load_data, exp_ld);
      if (exp_rd || exp_wr) begin
        chk("bus_addr", bus_addr, exp_addr);
        chk("bus_sel", bus_sel, exp_sel);
        if (exp_wr) chk("bus_wdata", bus_wdata, exp_wdata);
      end
    end
    if (bus_read) cap_rd = 1'b1;
    if (bus_write) cap_wr = 1'b1;
    if (bus_read || bus_write) begin
      cap_addr = bus_addr;
      cap_sel = bus_sel;
      cap_wdata = bus_wdata;
    end
    if (done) n_done++;
    if (misaligned) n_mis++;
    if (stall) run++;
    else if (run != 0) begin
      last_run = run;
      run = 0;
    end
  end

  task automatic clear_caps();
    cap_rd = 1'b0;
    cap_wr = 1'b0;
    cap_addr = '0;
    cap_sel = '0;
    cap_wdata = '0;
    d0 = n_done;
    m0 = n_mis;
  endtask

  // Called just after a rising edge; returns just after the edge that ends the DONE cycle.
  task automatic run_instr(input bit wr, input bit also_rd, input logic [31:0] a, input logic [2:0] f3,
                           input logic [31:0] sd, input logic [31:0] rdata, input int waits);
    logic f = model_fault(f3, a[1:0]);
    mem_write = wr;
    mem_read = !wr || also_rd;
    write_address = wr ? a : $urandom;
    read_address = wr ? $urandom : a;
    store_data = sd;
    funct3 = f3;
    bus_ack = 1'($urandom % 2);
    bus_rdata = $urandom;
    exp_stall = 1'b1;
    exp_rd = 1'b0;
    exp_wr = 1'b0;
    exp_done = 1'b0;
    exp_mis = 1'b0;
    @(posedge clk); #1;
    if (!f) begin
      for (int i = 0; i <= waits; i++) begin
        exp_rd = !wr;
        exp_wr = wr;
        exp_addr = {a[31:2], 2'b00};
        exp_sel = model_sel(f3, a[1:0], wr);
        exp_wdata = model_wdata(f3, sd);
        bus_ack = i == waits;
        bus_rdata = i == waits ? rdata : $urandom;
        @(posedge clk); #1;
      end
      if (!wr) exp_ld = model_ext(rdata, a[1:0], f3);
    end
    exp_stall = 1'b0;
    exp_rd = 1'b0;
    exp_wr = 1'b0;
    exp_done = 1'b1;
    exp_mis = f;
    bus_ack = 1'($urandom % 2);
    bus_rdata = $urandom;
    @(posedge clk); #1;
    mem_read = 1'b0;
    mem_write = 1'b0;
    exp_done = 1'b0;
    exp_mis = 1'b0;
    bus_ack = 1'($urandom % 2);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      bus_ack = 1'($urandom % 2);
      bus_rdata = $urandom;
      @(posedge clk); #1;
    end
  endtask

  initial begin
    logic [31:0] a;
    bit wr;
    nRst = 1'b0;
    mem_read = 1'b0;
    mem_write = 1'b0;
    read_address = '0;
    write_address = '0;
    store_data = '0;
    funct3 = '0;
    bus_rdata = '0;
    bus_ack = 1'b0;
    #2;
    chk("rst_bus_addr", bus_addr, 32'h0);
    chk("rst_bus_wdata", bus_wdata, 32'h0);
    chk("rst_bus_sel", bus_sel, 32'h0);
    chk("rst_strobes", {bus_read, bus_write}, 32'h0);
    chk("rst_load_data", load_data, 32'h0);
    chk("rst_done_mis", {done, misaligned}, 32'h0);
    chk("rst_stall_idle", stall, 32'h0);
    mem_read = 1'b1;
    #1 chk("rst_stall_req", stall, 32'h1);
    mem_read = 1'b0;
    @(posedge clk); #1;
    nRst = 1'b1;
    check_en = 1'b1;

    clear_caps();
    run_instr(1'b0, 1'b0, 32'h100, 3'b010, 32'h0, 32'hDEADBEEF, 2);
    chk("lw_data", load_data, 32'hDEADBEEF);
    chk("lw_addr", cap_addr, 32'h100);
    chk("lw_stall_cycles", last_run, 32'd4);
    chk("lw_done_count", n_done - d0, 32'd1);

    run_instr(1'b0, 1'b0, 32'h103, 3'b000, 32'h0, 32'h80112233, 0);
    chk("lb_data", load_data, 32'hFFFFFF80);
    chk("lb_stall_cycles", last_run, 32'd2);
    run_instr(1'b0, 1'b0, 32'h103, 3'b100, 32'h0, 32'h80112233, 1);
    chk("lbu_data", load_data, 32'h00000080);

    clear_caps();
    run_instr(1'b1, 1'b0, 32'h202, 3'b000, 32'h000000A5, 32'h0, 0);
    chk("sb_sel", cap_sel, 32'b0100);
    chk("sb_wdata", cap_wdata, 32'hA5A5A5A5);
    chk("sb_addr", cap_addr, 32'h200);
    run_instr(1'b1, 1'b0, 32'h202, 3'b001, 32'h0000BEEF, 32'h0, 1);
    chk("sh_sel", cap_sel, 32'b1100);
    chk("sh_wdata", cap_wdata, 32'hBEEFBEEF);

    clear_caps();
    run_instr(1'b0, 1'b0, 32'h101, 3'b010, 32'h0, 32'h12345678, 0);
    chk("mis_no_read", cap_rd, 32'h0);
    chk("mis_load_kept", load_data, 32'h00000080);
    chk("mis_stall_cycles", last_run, 32'd1);
    chk("mis_count", n_mis - m0, 32'd1);
    chk("mis_done_count", n_done - d0, 32'd1);

    clear_caps();
    run_instr(1'b1, 1'b1, 32'h300, 3'b010, 32'h11223344, 32'h0, 1);
    chk("prio_no_read", cap_rd, 32'h0);
    chk("prio_write", cap_wr, 32'h1);
    chk("prio_wdata", cap_wdata, 32'h11223344);
    run_instr(1'b1, 1'b0, 32'h304, 3'b010, 32'h55667788, 32'h0, 0);
    chk("b2b_addr", cap_addr, 32'h304);

    mem_read = 1'b1;
    read_address = 32'h400;
    funct3 = 3'b010;
    bus_ack = 1'b0;
    exp_stall = 1'b1;
    @(posedge clk); #1;
    exp_rd = 1'b1;
    exp_addr = 32'h400;
    exp_sel = 4'hF;
    #2 nRst = 1'b0;
    #1;
    chk("midrst_bus_read", bus_read, 32'h0);
    chk("midrst_done", done, 32'h0);
    chk("midrst_stall", stall, 32'h1);
    chk("midrst_load_data", load_data, 32'h0);
    exp_rd = 1'b0;
    exp_ld = '0;
    d0 = n_done;
    @(posedge clk); #1;
    nRst = 1'b1;
    mem_read = 1'b0;
    bus_ack = 1'b1;
    exp_stall = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    bus_ack = 1'b0;
    chk("late_ack_no_done", n_done - d0, 32'd0);

    for (int n = 0; n < 300; n++) begin
      wr = 1'($urandom % 2);
      a = $urandom;
      if ($urandom % 2 == 0) a[1:0] = 2'b00;
      run_instr(wr, wr && ($urandom % 4 == 0), a,
                wr ? st_f3[$urandom % 6] : 3'($urandom % 8),
                $urandom, $urandom, int'($urandom % 4));
      idle(int'($urandom % 3));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
